decode_stage: RTL and testbench



---
 rtl/decode_stage_if.sv | 34 +++
 rtl/decode_stage.sv | 241 ++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Fetch-to-execute bus of the decode stage.
// The raw instruction goes in on one side and the decoded entry comes out on the other.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [2:0]      out_kind;
  logic [3:0]      out_func;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_kind, out_func, out_rd, out_rs1, out_rs2,
           out_imm, out_pc, out_instr, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_kind, out_func, out_rd, out_rs1, out_rs2,
           out_imm, out_pc, out_instr, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I integer decoder (OP_IMM, OP, LUI, AUIPC) between fetch and execute.
// Uses an output register plus a skid register so that in_ready comes only from registered state.
module decode_stage #(
  parameter int XLEN      = 32,
  parameter int ENABLE_OP = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  decode_stage_if.slave bus
);

  localparam int SHW = (XLEN == 64) ? 6 : 5;
  localparam int HIW = 12 - SHW;
  localparam logic [HIW-1:0] BIT30 = HIW'(1) << (10 - SHW);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    K_ILLEGAL = 3'd0,
    K_OP_IMM  = 3'd1,
    K_OP      = 3'd2,
    K_LUI     = 3'd3,
    K_AUIPC   = 3'd4
  } kind_e;

  typedef enum logic [3:0] {
    F_ADD  = 4'd0,
    F_SUB  = 4'd1,
    F_SLT  = 4'd2,
    F_SLTU = 4'd3,
    F_AND  = 4'd4,
    F_OR   = 4'd5,
    F_XOR  = 4'd6,
    F_SLL  = 4'd7,
    F_SRL  = 4'd8,
    F_SRA  = 4'd9
  } func_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]      kind;
    logic [3:0]      func;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  state_t          state, next_state;
  entry_t          out_q, skid_q, dec;
  logic            load_out, load_out_from_skid, load_skid;
  logic            accept;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [HIW-1:0]  shift_hi;
  logic [XLEN-1:0] shamt;
  logic            dec_legal;
  kind_e           dec_kind;
  func_e           dec_func;
  logic [4:0]      dec_rd, dec_rs1, dec_rs2;
  logic [XLEN-1:0] dec_imm;

  // Decode straight off the input so both buffer registers only ever hold decoded entries.
  always_comb begin
    opcode    = bus.in_instr[6:0];
    funct3    = bus.in_instr[14:12];
    funct7    = bus.in_instr[31:25];
    shift_hi  = bus.in_instr[31:20+SHW];
    shamt     = XLEN'(bus.in_instr[20 +: SHW]);
    dec_legal = 1'b0;
    dec_kind  = K_ILLEGAL;
    dec_func  = F_ADD;
    dec_rd    = bus.in_instr[11:7];
    dec_rs1   = '0;
    dec_rs2   = '0;
    dec_imm   = '0;
    case (opcode)
      OPC_OP_IMM: begin
        dec_legal = 1'b1;
        dec_kind  = K_OP_IMM;
        dec_rs1   = bus.in_instr[19:15];
        dec_imm   = XLEN'($signed(bus.in_instr[31:20]));
        case (funct3)
          3'b000: dec_func = F_ADD;
          3'b010: dec_func = F_SLT;
          3'b011: dec_func = F_SLTU;
          3'b111: dec_func = F_AND;
          3'b110: dec_func = F_OR;
          3'b100: dec_func = F_XOR;
          3'b001: begin
            dec_func  = F_SLL;
            dec_imm   = shamt;
            dec_legal = (shift_hi == '0);
          end
          default: begin
            dec_func  = bus.in_instr[30] ? F_SRA : F_SRL;
            dec_imm   = shamt;
            dec_legal = ((shift_hi & ~BIT30) == '0);
          end
        endcase
      end
      OPC_OP: begin
        dec_kind = K_OP;
        dec_rs1  = bus.in_instr[19:15];
        dec_rs2  = bus.in_instr[24:20];
        if (ENABLE_OP != 0) begin
          if (funct7 == 7'b0000000) begin
            dec_legal = 1'b1;
            case (funct3)
              3'b000:  dec_func = F_ADD;
              3'b001:  dec_func = F_SLL;
              3'b010:  dec_func = F_SLT;
              3'b011:  dec_func = F_SLTU;
              3'b100:  dec_func = F_XOR;
              3'b101:  dec_func = F_SRL;
              3'b110:  dec_func = F_OR;
              default: dec_func = F_AND;
            endcase
          end else if (funct7 == 7'b0100000) begin
            if (funct3 == 3'b000) begin
              dec_legal = 1'b1;
              dec_func  = F_SUB;
            end else if (funct3 == 3'b101) begin
              dec_legal = 1'b1;
              dec_func  = F_SRA;
            end
          end
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_legal = 1'b1;
        dec_kind  = (opcode == OPC_LUI) ? K_LUI : K_AUIPC;
        dec_imm   = XLEN'($signed({bus.in_instr[31:12], 12'b0}));
      end
      default: dec_legal = 1'b0;
    endcase

    dec       = '0;
    dec.pc    = bus.in_pc;
    dec.instr = bus.in_instr;
    if (dec_legal) begin
      dec.kind = dec_kind;
      dec.func = dec_func;
      dec.rd   = dec_rd;
      dec.rs1  = dec_rs1;
      dec.rs2  = dec_rs2;
      dec.imm  = dec_imm;
    end
  end

  assign accept = bus.in_valid && (state != TWO);

  // Buffer control: the skid register only fills when the output is stalled.
  always_comb begin
    next_state         = state;
    load_out           = 1'b0;
    load_out_from_skid = 1'b0;
    load_skid          = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          next_state = ONE;
          load_out   = 1'b1;
        end
      end
      ONE: begin
        if (accept && bus.out_ready) begin
          load_out = 1'b1;
        end else if (accept) begin
          load_skid  = 1'b1;
          next_state = TWO;
        end else if (bus.out_ready) begin
          next_state = EMPTY;
        end
      end
      TWO: begin
        if (bus.out_ready) begin
          load_out_from_skid = 1'b1;
          next_state         = ONE;
        end
      end
      default: next_state = EMPTY;
    endcase
    if (flush) begin
      next_state         = EMPTY;
      load_out           = 1'b0;
      load_out_from_skid = 1'b0;
      load_skid          = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out) begin
        out_q <= dec;
      end else if (load_out_from_skid) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec;
      end
    end
  end

  assign bus.in_ready    = (state != TWO);
  assign bus.out_valid   = (state != EMPTY);
  assign bus.out_kind    = out_q.kind;
  assign bus.out_func    = out_q.func;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_rs1     = out_q.rs1;
  assign bus.out_rs2     = out_q.rs2;
  assign bus.out_imm     = out_q.imm;
  assign bus.out_pc      = out_q.pc;
  assign bus.out_instr   = out_q.instr;
  assign bus.out_illegal = (out_q.kind == K_ILLEGAL);

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: one instance with OP enabled and one with it disabled, fed the same stream.
// Expected entries are queued on accept and popped by per-instance monitors on each transfer.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_ready;

  int checks;
  int failures;
  int cycle;

  logic [127:0] exp_a[$];
  logic [127:0] exp_b[$];
  int           pop_cycles[$];

  decode_stage_if #(.XLEN(32)) bus_a ();
  decode_stage_if #(.XLEN(32)) bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_instr  = in_instr;
  assign bus_a.in_pc     = in_pc;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_instr  = in_instr;
  assign bus_b.in_pc     = in_pc;
  assign bus_b.out_ready = out_ready;

  decode_stage #(.XLEN(32), .ENABLE_OP(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus_a)
  );

  decode_stage #(.XLEN(32), .ENABLE_OP(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [127:0] entry(input logic [2:0] kind, input logic [3:0] func,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [31:0] imm,
                                         input logic [31:0] pc, input logic [31:0] instr);
    return {9'd0, kind, func, rd, rs1, rs2, imm, pc, instr, (kind == 3'd0)};
  endfunction

  function automatic logic [127:0] packA();
    return {9'd0, bus_a.out_kind, bus_a.out_func, bus_a.out_rd, bus_a.out_rs1, bus_a.out_rs2,
            bus_a.out_imm, bus_a.out_pc, bus_a.out_instr, bus_a.out_illegal};
  endfunction

  function automatic logic [127:0] packB();
    return {9'd0, bus_b.out_kind, bus_b.out_func, bus_b.out_rd, bus_b.out_rs1, bus_b.out_rs2,
            bus_b.out_imm, bus_b.out_pc, bus_b.out_instr, bus_b.out_illegal};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present one instruction, wait (bounded) for in_ready, and queue its expected decode.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                               input logic [127:0] exp);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    while (!bus_a.in_ready && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (waited >= 50) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout actual=no_in_ready required=in_ready pc=%h", pc);
    end else begin
      exp_a.push_back(exp);
      if (instr[6:0] == 7'b0110011)
        exp_b.push_back(entry(3'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, pc, instr));
      else
        exp_b.push_back(exp);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && !flush && bus_a.out_valid && bus_a.out_ready) begin
      pop_cycles.push_back(cycle);
      if (exp_a.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL a_unexpected actual=%h required=no_output", packA());
      end else begin
        checkOutput("a_entry", packA(), exp_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && !flush && bus_b.out_valid && bus_b.out_ready) begin
      if (exp_b.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL b_unexpected actual=%h required=no_output", packB());
      end else begin
        checkOutput("b_entry", packB(), exp_b.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nb;
    int n;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    in_pc     = 32'd0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", 128'(bus_a.out_valid), 128'd0);
    checkOutput("reset_ready", 128'(bus_a.in_ready), 128'd1);
    checkOutput("reset_data", packA(), entry(3'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed decode vectors");
    out_ready = 1'b1;
    applyStimulus(32'hFFF00093, 32'h100, entry(3'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h100, 32'hFFF00093));
    checkOutput("latency_valid", 128'(bus_a.out_valid), 128'd1);
    applyStimulus(32'h40208033, 32'h104, entry(3'd2, 4'd1, 5'd0, 5'd1, 5'd2, 32'd0, 32'h104, 32'h40208033));
    applyStimulus(32'h00000073, 32'h108, entry(3'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h108, 32'h00000073));
    applyStimulus(32'h4030D093, 32'h10C, entry(3'd1, 4'd9, 5'd1, 5'd1, 5'd0, 32'd3, 32'h10C, 32'h4030D093));
    applyStimulus(32'h0030D093, 32'h110, entry(3'd1, 4'd8, 5'd1, 5'd1, 5'd0, 32'd3, 32'h110, 32'h0030D093));
    applyStimulus(32'h02009093, 32'h114, entry(3'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h114, 32'h02009093));
    applyStimulus(32'h002081B3, 32'h118, entry(3'd2, 4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h118, 32'h002081B3));
    applyStimulus(32'h40209033, 32'h11C, entry(3'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h11C, 32'h40209033));
    applyStimulus(32'h800000B7, 32'h120, entry(3'd3, 4'd0, 5'd1, 5'd0, 5'd0, 32'h80000000, 32'h120, 32'h800000B7));
    applyStimulus(32'h12345297, 32'h124, entry(3'd4, 4'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h124, 32'h12345297));
    applyStimulus(32'hFFF1B113, 32'h128, entry(3'd1, 4'd3, 5'd2, 5'd3, 5'd0, 32'hFFFFFFFF, 32'h128, 32'hFFF1B113));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("drained_valid", 128'(bus_a.out_valid), 128'd0);

    $display("[TB] backpressure");
    nb = pop_cycles.size();
    out_ready = 1'b0;
    applyStimulus(32'h00100093, 32'h200, entry(3'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'd1, 32'h200, 32'h00100093));
    checkOutput("bp_ready_after_first", 128'(bus_a.in_ready), 128'd1);
    applyStimulus(32'h00200113, 32'h204, entry(3'd1, 4'd0, 5'd2, 5'd0, 5'd0, 32'd2, 32'h204, 32'h00200113));
    checkOutput("bp_ready_after_second", 128'(bus_a.in_ready), 128'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("bp_hold_valid", 128'(bus_a.out_valid), 128'd1);
    checkOutput("bp_hold_rd", 128'(bus_a.out_rd), 128'd1);
    out_ready = 1'b1;
    applyStimulus(32'h00300193, 32'h208, entry(3'd1, 4'd0, 5'd3, 5'd0, 5'd0, 32'd3, 32'h208, 32'h00300193));
    applyStimulus(32'h00400213, 32'h20C, entry(3'd1, 4'd0, 5'd4, 5'd0, 5'd0, 32'd4, 32'h20C, 32'h00400213));
    repeat (3) @(posedge clk);
    #1;
    n = pop_cycles.size();
    checkOutput("bp_pop_count", 128'(n - nb), 128'd4);
    if (n - nb >= 4)
      checkOutput("bp_no_gap", 128'(pop_cycles[n-1] - pop_cycles[n-4]), 128'd3);

    $display("[TB] flush from TWO");
    out_ready = 1'b0;
    applyStimulus(32'h00500293, 32'h300, entry(3'd1, 4'd0, 5'd5, 5'd0, 5'd0, 32'd5, 32'h300, 32'h00500293));
    applyStimulus(32'h00600313, 32'h304, entry(3'd1, 4'd0, 5'd6, 5'd0, 5'd0, 32'd6, 32'h304, 32'h00600313));
    checkOutput("flush_pre_ready", 128'(bus_a.in_ready), 128'd0);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h00700393;
    in_pc     = 32'h308;
    out_ready = 1'b1;
    exp_a.delete();
    exp_b.delete();
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_valid", 128'(bus_a.out_valid), 128'd0);
    checkOutput("flush_ready", 128'(bus_a.in_ready), 128'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("flush_nothing_left", 128'(bus_a.out_valid), 128'd0);

    $display("[TB] reset while holding two entries");
    out_ready = 1'b0;
    applyStimulus(32'h00800413, 32'h400, entry(3'd1, 4'd0, 5'd8, 5'd0, 5'd0, 32'd8, 32'h400, 32'h00800413));
    applyStimulus(32'h00900493, 32'h404, entry(3'd1, 4'd0, 5'd9, 5'd0, 5'd0, 32'd9, 32'h404, 32'h00900493));
    #2;
    rst_n = 1'b0;
    #1;
    exp_a.delete();
    exp_b.delete();
    checkOutput("areset_valid", 128'(bus_a.out_valid), 128'd0);
    checkOutput("areset_ready", 128'(bus_a.in_ready), 128'd1);
    checkOutput("areset_data", packA(), entry(3'd0, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0));
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    applyStimulus(32'h00A00513, 32'h408, entry(3'd1, 4'd0, 5'd10, 5'd0, 5'd0, 32'd10, 32'h408, 32'h00A00513));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("final_queue_a", 128'(exp_a.size()), 128'd0);
    checkOutput("final_queue_b", 128'(exp_b.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
